// File: rtl/serial_logic_unit.sv
// Bit-serial logic processor: two WIDTH-bit shift registers combined one bit
// per cycle through a selectable logic function and result router.
module serial_logic_unit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       F,
  input  logic [1:0]       R,
  input  logic [CNT_W-1:0] Shifts,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f_q, f_d;
  logic [1:0]         r_q, r_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               done_q, done_d;
  logic               a_bit, b_bit, f_bit, msb_a, msb_b;
  logic [CNT_W-1:0]   s_eff;

  assign a_bit = a_q[0];
  assign b_bit = b_q[0];

  // Zero or out-of-range shift counts mean a full-width pass.
  assign s_eff = (Shifts == '0 || Shifts > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Shifts;

  always_comb begin
    f_bit = 1'b0;
    case (f_q)
      3'b000: f_bit = a_bit & b_bit;
      3'b001: f_bit = a_bit | b_bit;
      3'b010: f_bit = a_bit ^ b_bit;
      3'b011: f_bit = 1'b1;
      3'b100: f_bit = ~(a_bit & b_bit);
      3'b101: f_bit = ~(a_bit | b_bit);
      3'b110: f_bit = ~(a_bit ^ b_bit);
      default: f_bit = 1'b0;
    endcase
    msb_a = a_bit;
    msb_b = b_bit;
    case (r_q)
      2'b01: msb_b = f_bit;
      2'b10: msb_a = f_bit;
      2'b11: begin msb_a = b_bit; msb_b = a_bit; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Execute) begin
          state_d = SHIFT;
          cnt_d   = s_eff;
          f_d     = F;
          r_d     = R;
        end else begin
          if (LoadA) a_d = Din;
          if (LoadB) b_d = Din;
        end
      end
      SHIFT: begin
        a_d   = {msb_a, a_q[WIDTH-1:1]};
        b_d   = {msb_b, b_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
      end
      HOLD: begin
        // One operation per Execute assertion: wait for release.
        if (!Execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f_q     <= '0;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  assign A    = a_q;
  assign B    = b_q;
  assign Busy = (state_q == SHIFT);
  assign Done = done_q;

endmodule

// File: doc/serial_logic_unit.md
# serial_logic_unit

Parametrised bit-serial logic processor: two WIDTH-bit shift registers (A, B), a per-bit logic function unit, a result router and a sequencing FSM in one block. It generalises the fixed 8-bit serial processor with run-time shift count, latched operation fields and Busy/Done status. It sits behind the board-level input synchronisers/debouncers and drives the hex display and debug LEDs; every input is already synchronous to Clk.

## Interface
- WIDTH, 8, register width in bits, ≥2
- CNT_W, $clog2(WIDTH+1), width of Shifts and internal counter (derived, not overridden)

- Clk  input  1  system clock, all state on rising edge
- Reset  input  1  synchronous, active-high
- LoadA  input  1  level; load Din into A while idle
- LoadB  input  1  level; load Din into B while idle
- Execute  input  1  level; start one operation per assertion
- Din  input  WIDTH  load data
- F  input  3  function select
- R  input  2  routing select
- Shifts  input  CNT_W  shifts per operation; 0 or >WIDTH means WIDTH
- A  output  WIDTH  register A
- B  output  WIDTH  register B
- Busy  output  1  high while shifting
- Done  output  1  one-cycle pulse after final shift

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE: Execute=1 → SHIFT; latch F, R and effective shift count S (Shifts==0 or >WIDTH → WIDTH). Execute has priority over loads that cycle. Otherwise LoadA → A<=Din, LoadB → B<=Din; both may load the same cycle.
- SHIFT: each cycle A and B shift right one bit; a = A[0], b = B[0]; new MSBs come from router. Counter decrements; after S-th shift → HOLD, Done=1 next cycle.
- HOLD: waits for Execute=0, then → IDLE. Holding Execute produces exactly one operation.
- LoadA/LoadB ignored in SHIFT and HOLD. F/R/Shifts changes during an operation have no effect.
- Function f(a,b): 000 a&b, 001 a|b, 010 a^b, 011 1, 100 ~(a&b), 101 ~(a|b), 110 ~(a^b), 111 0.
- Router (new A MSB, new B MSB): 00 (a, b); 01 (a, f); 10 (f, b); 11 (b, a).
- After S=WIDTH shifts, R=00 leaves A,B unchanged; R=11 swaps them.
- Partial S: A[WIDTH-1:WIDTH-S] holds routed results of original bits [S-1:0] in order; low bits are original bits [WIDTH-1:S].

## Timing
- Reset: A=0, B=0, Busy=0, Done=0, state IDLE, counter 0, latched F/R=0. Reset during SHIFT/HOLD aborts immediately; no Done.
- Loads: Din visible on A/B the cycle after the edge sampling LoadA/LoadB.
- Edge 0 samples Execute=1 in IDLE; shifts occur at edges 1..S; Busy=1 from after edge 0 through edge S (S cycles); Done=1 for the single cycle after edge S; A/B final after edge S.
- Busy is decoded from state (no extra latency); Done is registered.
- Execute low at edge S+1 → IDLE after that edge; next Execute accepted at edge S+2 earliest.
- Busy and Done never high together.

## Test plan
- WIDTH=8: load A=0x33, B=0x55; F=000, R=10, Shifts=0, pulse Execute → Busy 8 cycles, Done one cycle, A=0x11, B=0x55.
- WIDTH=8: A=0x33, B=0x55, R=11, Shifts=8 → A=0x55, B=0x33; then R=00 → unchanged.
- WIDTH=8: A=0x33, B=0x55, F=010, R=01, Shifts=4 → Busy 4 cycles, A=0x33, B=0x65; Shifts=15 → 8 shifts.
- Execute held 30 cycles with LoadA=1, Din=0xFF during op → exactly one Done, A unaffected until back in IDLE; F changed mid-op has no effect.
- Reset at 3rd shift cycle → next cycle A=0, B=0, Busy=0, no Done; subsequent load + Execute works normally.
- WIDTH=12: A=0x0F0, F=011, R=10, Shifts=0 → Busy 12 cycles, A=0xFFF; F=111 → A=0x000.
